// File: rtl/checker_memory_pkg.sv
// Shared types, widths and the byte-merge helper for the checker memory.
package checker_memory_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned COLL_CNT_W = 16;
  localparam int unsigned MAX_DW     = 128;
  localparam int unsigned MAX_NB     = MAX_DW / BYTE_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Replace the bytes of old_w selected by mask with the matching bytes of new_w.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] mask);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (mask[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/checker_memory_bank.sv
// Raw dual-port byte-lane storage with registered read ports.
// Optional parity lane enabled by CHECKER_MEMORY_PARITY_EN.
module checker_memory_bank
  import checker_memory_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 11,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en_a,
  input  logic                 i_en_b,
  input  logic [AW-1:0]        i_addr_a,
  input  logic [AW-1:0]        i_addr_b,
  input  logic [DW/BYTE_W-1:0] i_we_a,
  input  logic [DW/BYTE_W-1:0] i_we_b,
  input  logic [DW-1:0]        i_di_a,
  input  logic [DW-1:0]        i_di_b,
  output logic [DW-1:0]        o_do_a,
  output logic [DW-1:0]        o_do_b
`ifdef CHECKER_MEMORY_PARITY_EN
  ,
  output logic [DW/BYTE_W-1:0] o_par_a,
  output logic [DW/BYTE_W-1:0] o_par_b
`endif
);

  localparam int unsigned NB = DW / BYTE_W;

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_do_a, r_do_b;
  logic [DW-1:0] w_wf_a, w_wf_b;

  assign w_wf_a = DW'(byte_merge(MAX_DW'(r_mem[i_addr_a]), MAX_DW'(i_di_a), MAX_NB'(i_we_a)));
  assign w_wf_b = DW'(byte_merge(MAX_DW'(r_mem[i_addr_b]), MAX_DW'(i_di_b), MAX_NB'(i_we_b)));

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NB; i++) begin
      // Port A is written last so it owns overlapping bytes of a same-word collision.
      if (i_we_b[i]) r_mem[i_addr_b][i*BYTE_W +: BYTE_W] <= i_di_b[i*BYTE_W +: BYTE_W];
      if (i_we_a[i]) r_mem[i_addr_a][i*BYTE_W +: BYTE_W] <= i_di_a[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_do_a <= '0;
      r_do_b <= '0;
    end else begin
      if (i_en_a) r_do_a <= (WRITE_FIRST != 0) ? w_wf_a : r_mem[i_addr_a];
      if (i_en_b) r_do_b <= (WRITE_FIRST != 0) ? w_wf_b : r_mem[i_addr_b];
    end
  end

  assign o_do_a = r_do_a;
  assign o_do_b = r_do_b;

`ifdef CHECKER_MEMORY_PARITY_EN
  logic [NB-1:0] r_par [2**AW];
  logic [NB-1:0] r_par_a, r_par_b;
  logic [NB-1:0] w_pin_a, w_pin_b;

  always_comb begin
    w_pin_a = '0;
    w_pin_b = '0;
    for (int i = 0; i < NB; i++) begin
      w_pin_a[i] = ^i_di_a[i*BYTE_W +: BYTE_W];
      w_pin_b[i] = ^i_di_b[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_we_b[i]) r_par[i_addr_b][i] <= w_pin_b[i];
      if (i_we_a[i]) r_par[i_addr_a][i] <= w_pin_a[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_par_a <= '0;
      r_par_b <= '0;
    end else begin
      if (i_en_a) r_par_a <= (WRITE_FIRST != 0) ?
                             ((r_par[i_addr_a] & ~i_we_a) | (w_pin_a & i_we_a)) : r_par[i_addr_a];
      if (i_en_b) r_par_b <= (WRITE_FIRST != 0) ?
                             ((r_par[i_addr_b] & ~i_we_b) | (w_pin_b & i_we_b)) : r_par[i_addr_b];
    end
  end

  assign o_par_a = r_par_a;
  assign o_par_b = r_par_b;
`endif

endmodule

// File: rtl/checker_memory_dp.sv
// Dual-port checker memory: clear FSM, collision arbitration/counting, optional parity check.
// Define CHECKER_MEMORY_PARITY_EN to enable per-byte parity storage and checking.
module checker_memory_dp
  import checker_memory_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 11,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  ENA,
  input  logic                  ENB,
  input  logic [AW-1:0]         ADDRA,
  input  logic [AW-1:0]         ADDRB,
  input  logic [DW/BYTE_W-1:0]  WEA,
  input  logic [DW/BYTE_W-1:0]  WEB,
  input  logic [DW-1:0]         DIA,
  input  logic [DW-1:0]         DIB,
  output logic [DW-1:0]         DOA,
  output logic [DW-1:0]         DOB,
  output logic                  busy,
  output logic                  collision,
  output logic [COLL_CNT_W-1:0] coll_count,
  output logic                  parity_err
);

  localparam int unsigned NB = DW / BYTE_W;

  state_e                r_state, w_state_next;
  logic [AW-1:0]         r_clr_addr, w_clr_addr_next;
  logic                  r_collision;
  logic [COLL_CNT_W-1:0] r_coll_count;
  logic                  w_ready, w_en_a, w_en_b, w_coll;
  logic [NB-1:0]         w_we_a, w_we_b;
  logic [AW-1:0]         w_addr_a;
  logic [DW-1:0]         w_di_a;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    unique case (r_state)
      CLEAR: begin
        if (&r_clr_addr) w_state_next = READY;
        else             w_clr_addr_next = r_clr_addr + AW'(1);
      end
      READY: w_state_next = READY;
    endcase
  end

  assign busy    = (r_state == CLEAR);
  assign w_ready = (r_state == READY);
  assign w_en_a  = w_ready & ENA;
  assign w_en_b  = w_ready & ENB;
  assign w_coll  = w_en_a & w_en_b & (ADDRA == ADDRB) & (|(WEA & WEB));

  // The clear engine borrows port A; no writes land on a reset edge.
  assign w_we_a   = !sys_rst_n ? '0 : (busy ? '1 : (w_en_a ? WEA : '0));
  assign w_we_b   = (sys_rst_n && w_en_b) ? WEB : '0;
  assign w_addr_a = busy ? r_clr_addr : ADDRA;
  assign w_di_a   = busy ? '0 : DIA;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_collision  <= 1'b0;
      r_coll_count <= '0;
    end else begin
      r_collision <= w_coll;
      if (w_coll && (r_coll_count != '1)) r_coll_count <= r_coll_count + COLL_CNT_W'(1);
    end
  end

  assign collision  = r_collision;
  assign coll_count = r_coll_count;

`ifdef CHECKER_MEMORY_PARITY_EN
  logic [NB-1:0] w_par_a, w_par_b, w_calc_a, w_calc_b;
  logic          r_chk_a, r_chk_b, r_parity_err;
`endif

  checker_memory_bank #(
    .DW          (DW),
    .AW          (AW),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_bank (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_en_a   (w_en_a),
    .i_en_b   (w_en_b),
    .i_addr_a (w_addr_a),
    .i_addr_b (ADDRB),
    .i_we_a   (w_we_a),
    .i_we_b   (w_we_b),
    .i_di_a   (w_di_a),
    .i_di_b   (DIB),
    .o_do_a   (DOA),
    .o_do_b   (DOB)
`ifdef CHECKER_MEMORY_PARITY_EN
    ,
    .o_par_a  (w_par_a),
    .o_par_b  (w_par_b)
`endif
  );

`ifdef CHECKER_MEMORY_PARITY_EN
  always_comb begin
    w_calc_a = '0;
    w_calc_b = '0;
    for (int i = 0; i < NB; i++) begin
      w_calc_a[i] = ^DOA[i*BYTE_W +: BYTE_W];
      w_calc_b[i] = ^DOB[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_chk_a      <= 1'b0;
      r_chk_b      <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_chk_a <= w_en_a;
      r_chk_b <= w_en_b;
      if ((r_chk_a && (w_calc_a != w_par_a)) || (r_chk_b && (w_calc_b != w_par_b)))
        r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_checker_memory_dp.sv
// Self-checking bench: read-first and write-first instances driven in parallel
// and compared against a word-array reference model.
module tb_checker_memory_dp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  addra = '0, addrb = '0;
  logic [3:0]  wea = '0, web = '0;
  logic [31:0] dia = '0, dib = '0;

  logic [31:0] doa_rf, dob_rf, doa_wf, dob_wf;
  logic        busy_rf, busy_wf, coll_rf, coll_wf, perr_rf, perr_wf;
  logic [15:0] cnt_rf, cnt_wf;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state and expectations.
  logic [31:0] m_mem [16];
  int          m_cnt;
  logic [31:0] e_doa_rf, e_doa_wf, e_dob_rf, e_dob_wf;
  logic        e_coll;

  always #5 clk = ~clk;

  checker_memory_dp #(.DW(32), .AW(4), .WRITE_FIRST(0)) u_dut_rf (
    .sys_clk(clk), .sys_rst_n(rst_n), .ENA(ena), .ENB(enb), .ADDRA(addra), .ADDRB(addrb),
    .WEA(wea), .WEB(web), .DIA(dia), .DIB(dib), .DOA(doa_rf), .DOB(dob_rf), .busy(busy_rf),
    .collision(coll_rf), .coll_count(cnt_rf), .parity_err(perr_rf)
  );

  checker_memory_dp #(.DW(32), .AW(4), .WRITE_FIRST(1)) u_dut_wf (
    .sys_clk(clk), .sys_rst_n(rst_n), .ENA(ena), .ENB(enb), .ADDRA(addra), .ADDRB(addrb),
    .WEA(wea), .WEB(web), .DIA(dia), .DIB(dib), .DOA(doa_wf), .DOB(dob_wf), .busy(busy_wf),
    .collision(coll_wf), .coll_count(cnt_wf), .parity_err(perr_wf)
  );

  function automatic logic [31:0] apply(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One ready-state cycle: drive, clock, update model, settle.
  task automatic drive(input logic a_en, input logic [3:0] a_ad, input logic [3:0] a_we,
                       input logic [31:0] a_di, input logic b_en, input logic [3:0] b_ad,
                       input logic [3:0] b_we, input logic [31:0] b_di);
    logic [31:0] old_a, old_b;
    ena = a_en; addra = a_ad; wea = a_we; dia = a_di;
    enb = b_en; addrb = b_ad; web = b_we; dib = b_di;
    @(posedge clk);
    old_a = m_mem[a_ad];
    old_b = m_mem[b_ad];
    if (a_en) begin e_doa_rf = old_a; e_doa_wf = apply(old_a, a_di, a_we); end
    if (b_en) begin e_dob_rf = old_b; e_dob_wf = apply(old_b, b_di, b_we); end
    e_coll = a_en && b_en && (a_ad == b_ad) && ((a_we & b_we) != 4'h0);
    // A has priority on overlapping bytes, so its bytes are applied last.
    if (b_en) m_mem[b_ad] = apply(m_mem[b_ad], b_di, b_we);
    if (a_en) m_mem[a_ad] = apply(m_mem[a_ad], a_di, a_we);
    if (e_coll && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_cnt = 0; e_coll = 1'b0;
    e_doa_rf = '0; e_doa_wf = '0; e_dob_rf = '0; e_dob_wf = '0;
  endtask

  // Release reset and count cycles with busy high; bounded so a stuck busy still ends.
  task automatic release_and_count(output int n);
    rst_n = 1'b1;
    n = 0;
    while ((busy_rf || busy_wf) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    n_chk++;
    if (busy_rf !== 1'b1 || doa_rf !== 32'h0 || dob_wf !== 32'h0 || cnt_rf !== 16'h0 ||
        coll_rf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b doa=%h dob=%h cnt=%h coll=%b, need busy=1 rest 0",
               busy_rf, doa_rf, dob_wf, cnt_rf, coll_rf);
    end
    release_and_count(n);
    n_chk++;
    if (n != 16) begin
      n_err++;
      $display("FAIL busy_length: got %0d cycles, need 16", n);
    end
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'(a), 4'h0, 32'h0, 1'b1, 4'(15 - a), 4'h0, 32'h0);
      n_chk++;
      if (doa_rf !== 32'h0 || dob_rf !== 32'h0 || doa_wf !== 32'h0 || dob_wf !== 32'h0) begin
        n_err++;
        $display("FAIL cleared_word %0d: doa=%h/%h dob=%h/%h, need 0", a, doa_rf, doa_wf,
                 dob_rf, dob_wf);
      end
    end
    n_chk++;
    if (perr_rf !== 1'b0 || perr_wf !== 1'b0) begin
      n_err++;
      $display("FAIL parity_after_clear: %b/%b, need 0", perr_rf, perr_wf);
    end
  endtask

  task automatic test_byte_merge();
    drive(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b1, 4'd3, 4'h2, 32'h00001100, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3, 4'h0, 32'h0);
    n_chk++;
    if (dob_rf !== 32'hDEAD11EF || dob_wf !== 32'hDEAD11EF) begin
      n_err++;
      $display("FAIL byte_merge: dob=%h/%h, need deadl1ef", dob_rf, dob_wf);
    end
    idle();
    n_chk++;
    if (dob_rf !== 32'hDEAD11EF) begin
      n_err++;
      $display("FAIL dob_hold: dob=%h, need dead11ef", dob_rf);
    end
  endtask

  task automatic test_write_first();
    drive(1'b1, 4'd5, 4'hF, 32'hCAFEF00D, 1'b0, 4'd0, 4'h0, 32'h0);
    n_chk++;
    if (doa_rf !== 32'h00000000 || doa_wf !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL write_first: rf=%h wf=%h, need 00000000 cafef00d", doa_rf, doa_wf);
    end
    // Cross-port: B reads the word A overwrites in the same cycle and sees the old value.
    drive(1'b1, 4'd5, 4'hF, 32'h12345678, 1'b1, 4'd5, 4'h0, 32'h0);
    n_chk++;
    if (dob_rf !== 32'hCAFEF00D || dob_wf !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL cross_port_old: dob=%h/%h, need cafef00d", dob_rf, dob_wf);
    end
  endtask

  task automatic test_collision();
    int n;
    apply_reset();
    release_and_count(n);
    drive(1'b1, 4'd7, 4'h3, 32'h11111111, 1'b1, 4'd7, 4'h6, 32'h22222222);
    n_chk++;
    if (coll_rf !== 1'b1 || cnt_rf !== 16'd1 || coll_wf !== 1'b1 || cnt_wf !== 16'd1) begin
      n_err++;
      $display("FAIL collision_pulse: coll=%b cnt=%0d, need 1 1", coll_rf, cnt_rf);
    end
    drive(1'b1, 4'd7, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    n_chk++;
    if (coll_rf !== 1'b0 || cnt_rf !== 16'd1 || doa_rf !== 32'h00221111) begin
      n_err++;
      $display("FAIL collision_after: coll=%b cnt=%0d word=%h, need 0 1 00221111",
               coll_rf, cnt_rf, doa_rf);
    end
    drive(1'b1, 4'd8, 4'h3, 32'hAAAAAAAA, 1'b1, 4'd8, 4'hC, 32'hBBBBBBBB);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd8, 4'h0, 32'h0);
    n_chk++;
    if (coll_rf !== 1'b0 || cnt_rf !== 16'd1 || dob_rf !== 32'hBBBBAAAA) begin
      n_err++;
      $display("FAIL disjoint_masks: coll=%b cnt=%0d word=%h, need 0 1 bbbbaaaa",
               coll_rf, cnt_rf, dob_rf);
    end
  endtask

  task automatic test_random();
    logic a_en, b_en;
    logic [3:0] a_ad, b_ad, a_we, b_we;
    for (int c = 0; c < 400; c++) begin
      a_en = 1'($urandom_range(0, 3) != 0);
      b_en = 1'($urandom_range(0, 3) != 0);
      a_ad = 4'($urandom_range(0, 3));
      b_ad = 4'($urandom_range(0, 3));
      a_we = 4'($urandom);
      b_we = 4'($urandom);
      drive(a_en, a_ad, a_we, $urandom, b_en, b_ad, b_we, $urandom);
      n_chk++;
      if (doa_rf !== e_doa_rf || doa_wf !== e_doa_wf || dob_rf !== e_dob_rf ||
          dob_wf !== e_dob_wf || coll_rf !== e_coll || cnt_rf !== 16'(m_cnt) ||
          cnt_wf !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL random c%0d: doa=%h/%h dob=%h/%h coll=%b cnt=%0d, need %h/%h %h/%h %b %0d",
                 c, doa_rf, doa_wf, dob_rf, dob_wf, coll_rf, cnt_rf,
                 e_doa_rf, e_doa_wf, e_dob_rf, e_dob_wf, e_coll, m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    apply_reset();
    release_and_count(n);
    for (int c = 0; c < 70000; c++)
      drive(1'b1, 4'd9, 4'h1, 32'h1, 1'b1, 4'd9, 4'h1, 32'h2);
    n_chk++;
    if (cnt_rf !== 16'hFFFF || cnt_wf !== 16'hFFFF || coll_rf !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: cnt=%h/%h coll=%b, need ffff ffff 1", cnt_rf, cnt_wf, coll_rf);
    end
    idle();
    n_chk++;
    if (cnt_rf !== 16'hFFFF || coll_rf !== 1'b0) begin
      n_err++;
      $display("FAIL saturate_hold: cnt=%h coll=%b, need ffff 0", cnt_rf, coll_rf);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    drive(1'b1, 4'd12, 4'hF, 32'h5A5A5A5A, 1'b1, 4'd4, 4'hF, 32'hA5A5A5A5);
    apply_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin @(posedge clk); #1; end
    apply_reset();
    release_and_count(n);
    n_chk++;
    if (n != 16) begin
      n_err++;
      $display("FAIL restart_busy: got %0d cycles, need 16", n);
    end
    drive(1'b1, 4'd12, 4'h0, 32'h0, 1'b1, 4'd4, 4'h0, 32'h0);
    n_chk++;
    if (doa_rf !== 32'h0 || dob_rf !== 32'h0 || doa_wf !== 32'h0 || dob_wf !== 32'h0) begin
      n_err++;
      $display("FAIL restart_cleared: a12=%h/%h b4=%h/%h, need 0", doa_rf, doa_wf,
               dob_rf, dob_wf);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_byte_merge();
    test_write_first();
    test_collision();
    test_random();
    test_reset_mid_clear();
    test_saturate();
    n_chk++;
    if (perr_rf !== 1'b0 || perr_wf !== 1'b0) begin
      n_err++;
      $display("FAIL parity_final: %b/%b, need 0", perr_rf, perr_wf);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/checker_memory_dp.md
# checker_memory_dp

Parametrised, single-clock, true dual-port byte-lane memory for the checker core, replacing the fixed 32-bit/2048-byte checker memory. Adds arbitrary byte-enable masks, word addressing, a post-reset hardware clear engine, same-word write-collision arbitration with counting, and optional per-byte parity. It sits between the checker's capture logic (port A) and the host-readout path (port B).

## Interface
- DW, 32, data width in bits; multiple of 8, 8..128
- AW, 11, word-address width; depth = 2^AW words
- WRITE_FIRST, 0, 0 = read-first, 1 = write-first on a same-port read/write
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- ENA / ENB  in  1  port access enable
- ADDRA / ADDRB  in  AW  word address
- WEA / WEB  in  DW/8  byte-write enables, any mask legal
- DIA / DIB  in  DW  write data
- DOA / DOB  out  DW  registered read data
- busy  out  1  clear engine running; accesses ignored
- collision  out  1  one-cycle pulse: same-word write overlap
- coll_count  out  16  saturating collision counter
- parity_err  out  1  sticky parity error (see Configuration)

## Operation
- FSM states: CLEAR, READY. sys_rst_n=0 at an edge: state<=CLEAR, clr_addr<=0, DOA/DOB<=0, collision<=0, coll_count<=0, parity_err<=0, busy<=1.
- CLEAR: one word per cycle written to all-zero (parity bits 0); clr_addr increments; at clr_addr = 2^AW-1 write it, then state<=READY, busy<=0. No wrap; reset mid-clear restarts at 0.
- While busy: ENA/ENB ignored, no writes, DOA/DOB held at 0, no collisions counted.
- READY, port X with ENX=1: bytes i with WEX[i]=1 get DIX[8i+7:8i]; DOX updated next edge. ENX=0: no write, DOX holds.
- Same-port read/write: WRITE_FIRST=0 → DOX = old word; WRITE_FIRST=1 → DOX = old word with written bytes replaced.
- Cross-port, same address, A writes while B reads (or vice versa): reader always gets the old word.
- Collision: ENA & ENB & ADDRA==ADDRB & (WEA & WEB)!=0. Overlapping bytes take port A data; non-overlapping enabled bytes from both ports written. collision=1 on the following cycle only; coll_count +1, saturates at 0xFFFF.
- Both ports write same word with disjoint masks: both applied, no collision.

## Timing
- Read latency 1 cycle, both ports, full throughput every cycle.
- busy is 1 for exactly 2^AW cycles after the first edge with sys_rst_n=1; first accepted access is at edge 2^AW after release.
- collision and coll_count update together, 1 cycle after the colliding access.

## Configuration
- CHECKER_MEMORY_PARITY_EN defined: one even-parity bit stored per byte, written with the byte; on each enabled read the returned word's bytes are checked and any mismatch sets parity_err 1 cycle after DOX is valid; parity_err sticky until reset.
- Undefined: no parity storage or checking; parity_err tied to 0.

## Structure
- Package checker_memory_pkg: BYTE_W=8, COLL_CNT_W=16, FSM state encoding (CLEAR, READY), byte-merge function (old, new, mask).
- Sub-module checker_memory_bank: raw dual-port storage array (DW/8 lanes, plus parity lane when enabled), per-lane write enables, read-first/write-first read registers; top holds FSM, arbitration, counters.

## Test plan
- AW=4: release reset -> busy=1 for exactly 16 cycles; reading all 16 words afterwards returns 0; parity_err=0.
- A writes 0xDEADBEEF to addr 3 WEA=0xF, then WEA=0x2 data 0x00001100 -> B reads addr 3 = 0xDEAD11EF one cycle after request.
- WRITE_FIRST=0 vs 1: A reads and writes 0xCAFEF00D to addr 5 holding 0 -> DOA=0x00000000 vs 0xCAFEF00D.
- Same cycle, addr 7: A writes 0x11111111 WEA=0x3, B writes 0x22222222 WEB=0x6 -> word = 0x00221111; collision pulses once; coll_count=1. Disjoint masks 0x3/0xC -> no collision.
- Drive 70000 colliding cycles -> coll_count stops at 0xFFFF.
- Assert sys_rst_n=0 for 1 cycle during CLEAR at clr_addr=9 -> clear restarts, busy lasts a full 16 cycles after release; previously written data reads 0.
